// File: rtl/fetch_pkg.sv
// Shared types and defaults for the flash sample fetcher: FSM states, song commands,
// address step sizes and the default song map.
package fetch_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RD_LO, S_RD_HI, S_DONE} fetch_state_t;

  // Encoding order doubles as priority: lower non-zero value wins.
  typedef enum logic [1:0] {CMD_NONE, CMD_NEXT, CMD_PREV, CMD_RESTART} song_cmd_t;

  localparam logic [2:0] STEP_NORMAL = 3'd2;
  localparam logic [2:0] STEP_FAST   = 3'd4;

  localparam logic [22:0] SONG_START [2] = '{23'h000000, 23'h200000};
  localparam logic [22:0] SONG_END   [2] = '{23'h200000, 23'h400000};

  function automatic song_cmd_t pick_cmd(input song_cmd_t a, input song_cmd_t b);
    if (a == CMD_NONE) return b;
    if (b == CMD_NONE) return a;
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Sample address generator: owns cur_addr, song select, repeat flag and the command latch.
// Updates on the advance strobe (one per emitted sample) or immediately for idle-time commands.
module fetch_addr_gen
  import fetch_pkg::*;
#(
  parameter logic [22:0] SONG0_START = SONG_START[0],
  parameter logic [22:0] SONG0_END   = SONG_END[0],
  parameter logic [22:0] SONG1_START = SONG_START[1],
  parameter logic [22:0] SONG1_END   = SONG_END[1]
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        busy,
  input  logic        fast,
  input  logic        slow,
  input  logic        next_song,
  input  logic        prev_song,
  input  logic        restart,
  output logic [22:0] cur_addr,
  output logic        song_sel
);

  song_cmd_t   cmd_in, cmd_latch, cmd_apply;
  logic        rep, rep_next;
  logic [2:0]  step;
  logic [23:0] nxt_sum;
  logic [22:0] start_cur, end_cur, start_other;

  always_comb begin
    cmd_in = CMD_NONE;
    if (next_song)      cmd_in = CMD_NEXT;
    else if (prev_song) cmd_in = CMD_PREV;
    else if (restart)   cmd_in = CMD_RESTART;

    // Latched commands replace the step at sample end; idle commands apply at once.
    cmd_apply = CMD_NONE;
    if (advance)    cmd_apply = pick_cmd(cmd_latch, cmd_in);
    else if (!busy) cmd_apply = cmd_in;

    step     = STEP_NORMAL;
    rep_next = 1'b0;
    if (fast && !slow) begin
      step = STEP_FAST;
    end else if (slow && !fast) begin
      step     = rep ? STEP_NORMAL : 3'd0;
      rep_next = ~rep;
    end

    start_cur   = song_sel ? SONG1_START : SONG0_START;
    end_cur     = song_sel ? SONG1_END   : SONG0_END;
    start_other = song_sel ? SONG0_START : SONG1_START;
    nxt_sum     = {1'b0, cur_addr} + {21'b0, step};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= SONG0_START;
      song_sel  <= 1'b0;
      rep       <= 1'b0;
      cmd_latch <= CMD_NONE;
    end else begin
      if (cmd_apply == CMD_RESTART) begin
        cur_addr <= start_cur;
        rep      <= 1'b0;
      end else if (cmd_apply != CMD_NONE) begin
        // Two songs only, so next and prev both flip the selection.
        song_sel <= ~song_sel;
        cur_addr <= start_other;
        rep      <= 1'b0;
      end else if (advance) begin
        rep      <= rep_next;
        cur_addr <= (nxt_sum >= {1'b0, end_cur}) ? start_cur : nxt_sum[22:0];
      end else if (!slow) begin
        rep <= 1'b0;
      end

      if (advance)   cmd_latch <= CMD_NONE;
      else if (busy) cmd_latch <= pick_cmd(cmd_latch, cmd_in);
    end
  end

endmodule

// File: rtl/flash_sample_fetcher.sv
// Reads two flash bytes per codec request and presents them as a little-endian 16-bit sample.
// sample_valid follows sample_req by 2*WAIT_CYCLES+2 cycles; one extra request is queued while busy.
module flash_sample_fetcher
  import fetch_pkg::*;
#(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [22:0] SONG0_START = SONG_START[0],
  parameter logic [22:0] SONG0_END   = SONG_END[0],
  parameter logic [22:0] SONG1_START = SONG_START[1],
  parameter logic [22:0] SONG1_END   = SONG_END[1]
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        sample_req,
  input  logic        play,
  input  logic        restart,
  input  logic        fast,
  input  logic        slow,
  input  logic        next_song,
  input  logic        prev_song,
  input  logic [7:0]  FL_DQ,
  output logic [22:0] FL_ADDR,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic [15:0] musicData,
  output logic        sample_valid,
  output logic        SecondSong,
  output logic        busy
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  fetch_state_t state, nstate;
  logic [3:0]   cnt;
  logic [7:0]   lo, hi;
  logic         pending, advance, last;
  logic [22:0]  cur_addr;

  fetch_addr_gen #(
    .SONG0_START(SONG0_START), .SONG0_END(SONG0_END),
    .SONG1_START(SONG1_START), .SONG1_END(SONG1_END)
  ) u_addr (
    .clk(CLOCK), .rst(Reset), .advance(advance), .busy(busy), .fast(fast), .slow(slow),
    .next_song(next_song), .prev_song(prev_song), .restart(restart),
    .cur_addr(cur_addr), .song_sel(SecondSong)
  );

  assign last     = (cnt == CNT_LAST);
  assign FL_ADDR  = (state == S_RD_HI) ? cur_addr + 23'd1 : cur_addr;
  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = 1'b1;

  always_comb begin
    nstate  = state;
    busy    = 1'b0;
    FL_CE_N = 1'b1;
    FL_OE_N = 1'b1;
    advance = 1'b0;
    case (state)
      S_IDLE:  if ((sample_req || pending) && play) nstate = S_RD_LO;
      S_RD_LO: begin
        busy = 1'b1; FL_CE_N = 1'b0; FL_OE_N = 1'b0;
        if (last) nstate = S_RD_HI;
      end
      S_RD_HI: begin
        busy = 1'b1; FL_CE_N = 1'b0; FL_OE_N = 1'b0;
        if (last) nstate = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        advance = 1'b1;
        nstate  = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lo           <= '0;
      hi           <= '0;
      pending      <= 1'b0;
      musicData    <= '0;
      sample_valid <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= (nstate != state || state == S_IDLE) ? 4'd0 : cnt + 4'd1;
      if (state == S_RD_LO && last) lo <= FL_DQ;
      if (state == S_RD_HI && last) hi <= FL_DQ;
      // A queued request is consumed (or dropped when paused) on the first idle cycle.
      if (state == S_IDLE)  pending <= 1'b0;
      else if (sample_req)  pending <= 1'b1;
      sample_valid <= (state == S_DONE);
      if (state == S_DONE && play) musicData <= {hi, lo};
      else if (!play)              musicData <= '0;
    end
  end

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Directed bench: flash model returns addr[7:0]; a second instance with a 6-byte song 0 checks wrap.
module tb_flash_sample_fetcher;
  logic CLOCK = 1'b0, Reset = 1'b1;
  logic sample_req = 0, play = 1, restart = 0, fast = 0, slow = 0, next_song = 0, prev_song = 0;

  logic [22:0] addr1, addr2;
  logic [7:0]  dq1, dq2;
  logic ce_n1, oe_n1, we_n1, rst_n1, sv1, ss1, busy1;
  logic ce_n2, oe_n2, we_n2, rst_n2, sv2, ss2, busy2;
  logic [15:0] md1, md2;

  int total = 0;
  int bad = 0;

  always #5 CLOCK = ~CLOCK;
  assign dq1 = addr1[7:0];
  assign dq2 = addr2[7:0];

  flash_sample_fetcher dut (
    .CLOCK(CLOCK), .Reset(Reset), .sample_req(sample_req), .play(play), .restart(restart),
    .fast(fast), .slow(slow), .next_song(next_song), .prev_song(prev_song), .FL_DQ(dq1),
    .FL_ADDR(addr1), .FL_CE_N(ce_n1), .FL_OE_N(oe_n1), .FL_WE_N(we_n1), .FL_RST_N(rst_n1),
    .musicData(md1), .sample_valid(sv1), .SecondSong(ss1), .busy(busy1)
  );

  flash_sample_fetcher #(.SONG0_END(23'd6)) dut_wrap (
    .CLOCK(CLOCK), .Reset(Reset), .sample_req(sample_req), .play(play), .restart(restart),
    .fast(fast), .slow(slow), .next_song(next_song), .prev_song(prev_song), .FL_DQ(dq2),
    .FL_ADDR(addr2), .FL_CE_N(ce_n2), .FL_OE_N(oe_n2), .FL_WE_N(we_n2), .FL_RST_N(rst_n2),
    .musicData(md2), .sample_valid(sv2), .SecondSong(ss2), .busy(busy2)
  );

  typedef struct {
    logic        do_rst;
    logic        f;
    logic        s;
    logic [22:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge CLOCK);
    @(negedge CLOCK);
    Reset = 1'b0;
    @(negedge CLOCK);
  endtask

  // Called at a negedge; k counts cycles after the request cycle.
  task automatic run_req(output logic [15:0] data, output int lat, output logic [22:0] a_lo,
                         output logic [22:0] a_hi, output logic [22:0] a2, output int ce_low);
    data = '0; lat = -1; a_lo = '0; a_hi = '0; a2 = '0; ce_low = 0;
    sample_req = 1'b1;
    @(negedge CLOCK);
    sample_req = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 1) begin a_lo = addr1; a2 = addr2; end
      if (k == 5) a_hi = addr1;
      if (!ce_n1 && !oe_n1) ce_low++;
      if (sv1) begin lat = k; data = md1; break; end
      @(negedge CLOCK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[9];
    logic [15:0] d;
    int          lat, ce_low, n;
    int          vk[4];
    logic [15:0] vd[4];
    logic [22:0] a_lo, a_hi, a2;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 23'd0, 16'h0100};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 23'd2, 16'h0302};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 23'd0, 16'h0100};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 23'd4, 16'h0504};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 23'd8, 16'h0908};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 23'd0, 16'h0100};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 23'd0, 16'h0100};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 23'd2, 16'h0302};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 23'd2, 16'h0302};

    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("rst_addr", 32'(addr1), 32'h0);
    chk("rst_ce_n", 32'(ce_n1), 32'h1);
    chk("rst_oe_n", 32'(oe_n1), 32'h1);
    chk("rst_we_n", 32'(we_n1), 32'h1);
    chk("rst_flrst_n", 32'(rst_n1), 32'h1);
    chk("rst_music", 32'(md1), 32'h0);
    chk("rst_valid", 32'(sv1), 32'h0);
    chk("rst_second", 32'(ss1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    Reset = 1'b0;
    @(negedge CLOCK);

    // sample_req while paused is ignored
    play = 1'b0;
    sample_req = 1'b1;
    @(negedge CLOCK);
    sample_req = 1'b0;
    @(negedge CLOCK);
    chk("paused_req_busy", 32'(busy1), 32'h0);
    play = 1'b1;
    @(negedge CLOCK);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_rst) do_reset();
      fast = vecs[i].f;
      slow = vecs[i].s;
      @(negedge CLOCK);
      run_req(d, lat, a_lo, a_hi, a2, ce_low);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd10);
      chk($sformatf("vec%0d_addr_lo", i), 32'(a_lo), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_addr_hi", i), 32'(a_hi), 32'(vecs[i].exp_addr) + 32'd1);
      chk($sformatf("vec%0d_ce_cycles", i), 32'(ce_low), 32'd8);
    end
    fast = 1'b0;
    slow = 1'b0;

    // wrap on the 6-byte song
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_req(d, lat, a_lo, a_hi, a2, ce_low);
      chk($sformatf("wrap%0d_addr", i), 32'(a2), 32'((i % 3) * 2));
    end

    // one-deep pending request while busy
    do_reset();
    n = 0;
    sample_req = 1'b1;
    @(negedge CLOCK);
    for (int k = 1; k <= 30; k++) begin
      sample_req = (k == 3);
      if (sv1 && n < 4) begin vk[n] = k; vd[n] = md1; n++; end
      @(negedge CLOCK);
    end
    sample_req = 1'b0;
    chk("pend_count", 32'(n), 32'd2);
    if (n == 2) begin
      chk("pend_lat0", 32'(vk[0]), 32'd10);
      chk("pend_lat1", 32'(vk[1]), 32'd20);
      chk("pend_data1", 32'(vd[1]), 32'h0302);
    end

    // pause mutes output until the next sample after play returns
    play = 1'b0;
    @(negedge CLOCK);
    chk("pause_mute", 32'(md1), 32'h0);
    play = 1'b1;
    @(negedge CLOCK);
    chk("pause_stays_mute", 32'(md1), 32'h0);
    run_req(d, lat, a_lo, a_hi, a2, ce_low);
    chk("resume_data", 32'(d), 32'h0504);

    // next_song + restart mid-fetch: sample completes, next fetch from song 1
    do_reset();
    lat = -1;
    d = '0;
    sample_req = 1'b1;
    @(negedge CLOCK);
    sample_req = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      next_song = (k == 3);
      restart   = (k == 3);
      if (sv1) begin lat = k; d = md1; break; end
      @(negedge CLOCK);
    end
    next_song = 1'b0;
    restart = 1'b0;
    chk("cmd_cur_data", 32'(d), 32'h0100);
    chk("cmd_cur_lat", 32'(lat), 32'd10);
    chk("cmd_second", 32'(ss1), 32'h1);
    run_req(d, lat, a_lo, a_hi, a2, ce_low);
    chk("cmd_next_addr", 32'(a_lo), 32'h200000);
    chk("cmd_next_data", 32'(d), 32'h0100);

    // reset asserted during the high-byte read
    do_reset();
    run_req(d, lat, a_lo, a_hi, a2, ce_low);
    chk("prerst_data", 32'(md1), 32'h0100);
    sample_req = 1'b1;
    @(negedge CLOCK);
    sample_req = 1'b0;
    repeat (5) @(negedge CLOCK);
    chk("midrst_pre_addr", 32'(addr1), 32'd3);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_ce_n", 32'(ce_n1), 32'h1);
    chk("midrst_oe_n", 32'(oe_n1), 32'h1);
    chk("midrst_music", 32'(md1), 32'h0);
    chk("midrst_addr", 32'(addr1), 32'h0);
    @(negedge CLOCK);
    Reset = 1'b0;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      if (sv1) n++;
      @(negedge CLOCK);
    end
    chk("midrst_no_valid", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_sample_fetcher.md
Name: flash_sample_fetcher

Overview:
- Upstream audio-data stage: reads 8-bit flash bytes, assembles little-endian 16-bit PCM samples, and presents them on musicData to the audio interface.
- Paced by the audio interface's per-sample sync pulse, which arrives on sample_req.
- Applies transport state from the control unit: play/pause, restart, fast, slow, next song and previous song.
- Drives the flash control pins directly and reports which song region is active on SecondSong.

Parameters:
- WAIT_CYCLES, 4: CLOCK cycles the address is held before FL_DQ is captured (flash access time); legal range 1..15.
- SONG0_START, 23'h000000: first byte address of song 0 (even).
- SONG0_END, 23'h200000: exclusive end byte address of song 0 (even).
- SONG1_START, 23'h200000: first byte address of song 1 (even).
- SONG1_END, 23'h400000: exclusive end byte address of song 1 (even).

Ports:
- CLOCK  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- sample_req  in  1  one-cycle pulse; the codec wants the next sample
- play  in  1  level; 1 = Play state, 0 = Pause
- restart  in  1  one-cycle pulse; return to start of current song
- fast  in  1  level; 2x playback
- slow  in  1  level; 0.5x playback
- next_song  in  1  one-cycle pulse
- prev_song  in  1  one-cycle pulse
- FL_DQ  in  8  flash read data
- FL_ADDR  out  23  flash byte address
- FL_CE_N  out  1  chip enable, active low
- FL_OE_N  out  1  output enable, active low
- FL_WE_N  out  1  write enable; constant 1
- FL_RST_N  out  1  flash reset; constant 1
- musicData  out  16  current sample, {hi byte, lo byte}
- sample_valid  out  1  one-cycle pulse when musicData updates
- SecondSong  out  1  1 = song 1 active
- busy  out  1  fetch in progress

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - Outputs: FL_ADDR=SONG0_START, FL_CE_N=1, FL_OE_N=1, musicData=0, sample_valid=0, SecondSong=0, busy=0.
  - Internals: repeat flag=0, pending flags cleared, state=S_IDLE.
  - A fetch in flight is abandoned immediately; no partial sample is emitted.
- FSM states: S_IDLE, S_RD_LO, S_RD_HI, S_DONE.
- S_IDLE:
  - CE_N=1, OE_N=1, busy=0.
  - sample_req && play -> S_RD_LO.
  - sample_req while play=0 is ignored.
- S_RD_LO:
  - FL_ADDR=cur_addr, CE_N=0, OE_N=0, busy=1.
  - Held for WAIT_CYCLES cycles; FL_DQ is captured into lo on the last of them, then -> S_RD_HI.
- S_RD_HI:
  - FL_ADDR=cur_addr+1, CE_N=0, OE_N=0.
  - Held for WAIT_CYCLES cycles; hi is captured on the last of them, then -> S_DONE.
- S_DONE (1 cycle):
  - musicData <= {hi, lo}, sample_valid=1, CE_N=1, OE_N=1.
  - Address update is applied (rules below), then -> S_IDLE.
- Latency: sample_req in cycle N gives sample_valid in cycle N+2*WAIT_CYCLES+2 (N+10 at default).
- Request overlap: a sample_req arriving while busy sets a one-deep pending flag. It is serviced on the cycle after S_DONE if play is still 1. Additional requests while pending is set are dropped.
- Pause:
  - play=0 does not abort a fetch in progress.
  - musicData is forced to 0 on the cycle after play falls and stays 0 until the next S_DONE after play returns.
- Address step (S_DONE, no pending command):
  - fast=1, slow=0: step 4 (skip alternate samples).
  - slow=1, fast=0: repeat flag toggles; the address advances by 2 only when the flag was 1, so each sample is emitted twice.
  - Both or neither set: step 2.
  - The repeat flag clears whenever slow=0.
- Wrap: if cur_addr+step >= active song END, cur_addr <= active song START (looping). Computed in 24 bits so there is no overflow.
- Commands:
  - Priority when pulses coincide in one cycle: next_song > prev_song > restart.
  - With two songs, next and prev both toggle the song select.
  - A song change sets cur_addr to the new song's START and updates SecondSong in the same cycle.
  - restart sets cur_addr to the current song's START.
  - In S_IDLE, a command applies on the next edge.
  - While busy, the command is latched (highest priority kept) and applied in S_DONE in place of the normal step. The sample being fetched is still emitted.
  - The repeat flag clears on any command.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum.
  - STEP_NORMAL=2, STEP_FAST=4.
  - Song START/END constant arrays (default values).
  - song_cmd_t enum {CMD_NONE, CMD_NEXT, CMD_PREV, CMD_RESTART}.
- Sub-module fetch_addr_gen: owns cur_addr, song select, repeat flag, command latch, and the step/wrap arithmetic. Exposes an advance strobe from the FSM.
- The flash FSM and byte capture stay in the top module.

Test Plan:
- Reset, play=1, FL_DQ model returns byte = addr[7:0]; pulse sample_req -> FL_ADDR 0 then 1, CE_N/OE_N low for 8 cycles, sample_valid at req+10 with musicData=16'h0100; next sample 16'h0302.
- fast=1, three requests -> musicData 16'h0100, 16'h0504, 16'h0908.
- slow=1, four requests -> 16'h0100, 16'h0100, 16'h0302, 16'h0302.
- SONG0_END=6, six requests at normal speed -> addresses 0, 2, 4, 0, 2, 4 (wrap).
- Mid-fetch next_song and restart in the same cycle -> current sample completes; next fetch at SONG1_START with SecondSong=1; restart ignored.
- Reset asserted during S_RD_HI -> CE_N/OE_N=1 and musicData=0 asynchronously; no sample_valid; FL_ADDR=SONG0_START.
